branch_resolver: RTL and testbench
==================================

// Module: branch_resolver
// PURPOSE
//   Execute-side counterpart of the fetch branch predictor. Tracks in-flight fetch predictions
//   in order, compares each against the resolved outcome from execute, issues the front-end
//   redirect on mispredict, and drives the predictor update port (taken/pc/target) one cycle later.
// PARAMETERS
//   DEPTH         4   in-flight prediction entries (power of two, >=2)
//   TARGET_WIDTH  32  width of predicted/resolved targets
// PORTS
//   clk_i              in   1             clock
//   rstn_i             in   1             synchronous reset, active low
//   pushValid_i        in   1             fetch issues a control-flow instruction
//   pushReady_o        out  1             queue not full
//   pushPc_i           in   32            fetch PC of the instruction
//   pushPredTaken_i    in   1             predictor hit (predicted taken)
//   pushPredTarget_i   in   TARGET_WIDTH  predicted target
//   resValid_i         in   1             execute resolves the oldest branch
//   resPc_i            in   32            resolved instruction PC
//   resTaken_i         in   1             actual direction
//   resTarget_i        in   TARGET_WIDTH  actual target
//   resCompressed_i    in   1             16-bit instruction (fall-through +2, else +4)
//   flush_i            in   1             trap/external flush, empties queue
//   redirectValid_o    out  1             one-cycle pulse: refetch from redirectPc_o
//   redirectPc_o       out  32            corrected next PC
//   updValid_o         out  1             one-cycle pulse: predictor update valid
//   updTaken_o         out  1             -> predictor exTaken_i
//   updPc_o            out  32            -> predictor exPc_i
//   updTarget_o        out  TARGET_WIDTH  -> predictor exTarget_i
//   err_o              out  1             sticky: ordering violation
//   branchCnt_o        out  32            resolved branches (see CONFIGURATION)
//   mispredCnt_o       out  32            mispredictions (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: queue empty, all outputs 0 (pushReady_o=1 on first cycle after reset). Reset
//     mid-operation discards all entries and any pending redirect/update.
//   - Push accepted when pushValid_i && pushReady_o; pushReady_o = !full (push+pop at full is
//     NOT accepted same cycle). Pointers wrap modulo DEPTH; count holds 0..DEPTH.
//   - Resolve pops head when resValid_i && !empty. Mispredict if predTaken != resTaken_i, or
//     both taken and predTarget != resTarget_i (full-width compare).
//   - Outputs registered, latency 1: cycle after resolve, updValid_o=1 with res* values;
//     on mispredict redirectValid_o=1, redirectPc_o = resTaken_i ? resTarget_i
//     : resPc_i + (resCompressed_i ? 2 : 4) (mod 2^32).
//   - Mispredict flushes all younger entries on the same edge; a push in that cycle is dropped.
//   - resValid_i while empty, or resPc_i != head PC: set err_o (cleared only by reset), treat as
//     mispredict (redirect + update still emitted), queue flushed.
//   - flush_i: empties queue, suppresses redirect for a same-cycle resolve; update still emitted.
//   - Simultaneous push+pop (not full, no mispredict): count unchanged.
//   - Idle cycles: upd*/redirectPc_o hold 0 when their valid is low.
// CONFIGURATION
//   BRU_PERF_CNT_EN defined: branchCnt_o/mispredCnt_o increment per resolve/mispredict,
//   saturate at 32'hFFFF_FFFF, cleared by reset only. Not defined: counter flops absent,
//   both ports tied to 0 (ports kept for interface stability).
// STRUCTURE
//   bru_pkg: pred_entry_t struct {pc, predTaken, predTarget}; fall-through constants
//   (2/4); mispredict-cause enum (DIR, TARGET, ORDER).
//   Sub-module bru_pred_fifo: DEPTH-entry pred_entry_t FIFO with push/pop/flush, full/empty.
// TESTING
//   1 push pc=0x100 pred NT; resolve NT -> upd(taken=0,pc=0x100) next cycle, no redirect.
//   2 push pc=0x200 pred T tgt=0x300; resolve T tgt=0x340 -> redirectPc_o=0x340, queue empty.
//   3 push pc=0x400 pred T; resolve NT compressed -> redirectPc_o=0x402; NT 32-bit -> 0x404.
//   4 push DEPTH entries -> pushReady_o=0; extra push dropped; pop one -> ready=1, order kept.
//   5 resolve while empty / pc mismatch -> err_o=1 sticky, redirect to actual next PC.
//   6 flush_i with 3 entries + same-cycle push -> empty next cycle; BRU_PERF_CNT_EN counts match.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolver.
//   pred_entry_t    : one in-flight fetch prediction (pc, predicted direction, predicted target)
//   mispred_cause_e : why a resolve was treated as a mispredict
//   FALL_THROUGH_*  : sequential next-PC increments for 16-bit and 32-bit instructions
// Optional feature macro used by the top: BRU_PERF_CNT_EN.
package bru_pkg;

  localparam int unsigned BRU_PC_WIDTH     = 32;
  // Width of the target field stored per entry; the top's TARGET_WIDTH must not exceed it.
  localparam int unsigned BRU_TARGET_WIDTH = 32;

  localparam logic [BRU_PC_WIDTH-1:0] FALL_THROUGH_C = 32'd2;
  localparam logic [BRU_PC_WIDTH-1:0] FALL_THROUGH_N = 32'd4;

  typedef struct packed {
    logic [BRU_PC_WIDTH-1:0]     pc;
    logic                        pred_taken;
    logic [BRU_TARGET_WIDTH-1:0] pred_target;
  } pred_entry_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_DIR,
    CAUSE_TARGET,
    CAUSE_ORDER
  } mispred_cause_e;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order queue of in-flight predictions.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   push_i/entry_i: write entry at tail (ignored when full or flushing)
//   pop_i         : drop head entry (ignored when empty or flushing)
//   flush_i       : discard every entry; wins over push and pop
//   head_o        : oldest entry; full_o/empty_o status
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        push_i,
  input  pred_entry_t entry_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  pred_entry_t      mem_q [DEPTH];
  pred_entry_t      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full is evaluated before any same-cycle pop, so push+pop at full drops the push.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = entry_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Execute-side branch resolver: tracks fetch predictions in order, checks each against the
// resolved outcome, issues a front-end redirect on mispredict and drives the predictor update.
//   push*     : fetch-side prediction enqueue (pushReady_o = queue not full)
//   res*      : execute-side resolution of the oldest branch
//   flush_i   : empties the queue and suppresses a same-cycle redirect
//   redirect* : registered refetch pulse and corrected PC
//   upd*      : registered predictor update pulse and payload
//   err_o     : sticky ordering violation (resolve while empty or PC mismatch)
//   branchCnt_o / mispredCnt_o : saturating counters when BRU_PERF_CNT_EN is defined, else 0
module branch_resolver
  import bru_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TARGET_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    pushValid_i,
  output logic                    pushReady_o,
  input  logic [31:0]             pushPc_i,
  input  logic                    pushPredTaken_i,
  input  logic [TARGET_WIDTH-1:0] pushPredTarget_i,
  input  logic                    resValid_i,
  input  logic [31:0]             resPc_i,
  input  logic                    resTaken_i,
  input  logic [TARGET_WIDTH-1:0] resTarget_i,
  input  logic                    resCompressed_i,
  input  logic                    flush_i,
  output logic                    redirectValid_o,
  output logic [31:0]             redirectPc_o,
  output logic                    updValid_o,
  output logic                    updTaken_o,
  output logic [31:0]             updPc_o,
  output logic [TARGET_WIDTH-1:0] updTarget_o,
  output logic                    err_o,
  output logic [31:0]             branchCnt_o,
  output logic [31:0]             mispredCnt_o
);

  pred_entry_t    push_entry, head;
  logic           full, empty;
  mispred_cause_e cause;
  logic           mispred;
  logic [31:0]    next_pc;

  logic                    upd_valid_q, upd_valid_d;
  logic                    upd_taken_q, upd_taken_d;
  logic [31:0]             upd_pc_q, upd_pc_d;
  logic [TARGET_WIDTH-1:0] upd_target_q, upd_target_d;
  logic                    redirect_valid_q, redirect_valid_d;
  logic [31:0]             redirect_pc_q, redirect_pc_d;
  logic                    err_q, err_d;

  assign push_entry = '{pc:          pushPc_i,
                        pred_taken:  pushPredTaken_i,
                        pred_target: BRU_TARGET_WIDTH'(pushPredTarget_i)};

  always_comb begin
    cause = CAUSE_NONE;
    if (resValid_i) begin
      if (empty || (resPc_i != head.pc)) begin
        cause = CAUSE_ORDER;
      end else if (head.pred_taken != resTaken_i) begin
        cause = CAUSE_DIR;
      end else if (resTaken_i && (TARGET_WIDTH'(head.pred_target) != resTarget_i)) begin
        cause = CAUSE_TARGET;
      end
    end
  end

  assign mispred = (cause != CAUSE_NONE);
  assign next_pc = resTaken_i ? 32'(resTarget_i)
                              : resPc_i + (resCompressed_i ? FALL_THROUGH_C : FALL_THROUGH_N);

  // A mispredict squashes every younger entry, so the popped head goes with the flush and any
  // same-cycle push is dropped inside the FIFO.
  bru_pred_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (pushValid_i),
    .entry_i (push_entry),
    .pop_i   (resValid_i),
    .flush_i (flush_i || mispred),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pushReady_o = !full;

  always_comb begin
    upd_valid_d      = resValid_i;
    upd_taken_d      = resValid_i && resTaken_i;
    upd_pc_d         = resValid_i ? resPc_i : '0;
    upd_target_d     = resValid_i ? resTarget_i : '0;
    redirect_valid_d = mispred && !flush_i;
    redirect_pc_d    = redirect_valid_d ? next_pc : '0;
    err_d            = err_q || (cause == CAUSE_ORDER);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      upd_valid_q      <= 1'b0;
      upd_taken_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      err_q            <= 1'b0;
    end else begin
      upd_valid_q      <= upd_valid_d;
      upd_taken_q      <= upd_taken_d;
      upd_pc_q         <= upd_pc_d;
      upd_target_q     <= upd_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      err_q            <= err_d;
    end
  end

  assign updValid_o      = upd_valid_q;
  assign updTaken_o      = upd_taken_q;
  assign updPc_o         = upd_pc_q;
  assign updTarget_o     = upd_target_q;
  assign redirectValid_o = redirect_valid_q;
  assign redirectPc_o    = redirect_pc_q;
  assign err_o           = err_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resValid_i && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispred && (mispred_cnt_q != '1))   mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branchCnt_o  = branch_cnt_q;
  assign mispredCnt_o = mispred_cnt_q;
`else
  assign branchCnt_o  = '0;
  assign mispredCnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          pushValid, pushPredTaken, resValid, resTaken, resCompressed, flush;
  logic [31:0]   pushPc, resPc;
  logic [TW-1:0] pushPredTarget, resTarget;
  logic          pushReady_o, redirectValid_o, updValid_o, updTaken_o, err_o;
  logic [31:0]   redirectPc_o, updPc_o, branchCnt_o, mispredCnt_o;
  logic [TW-1:0] updTarget_o;

  branch_resolver #(.DEPTH(DEPTH), .TARGET_WIDTH(TW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .pushValid_i(pushValid), .pushReady_o(pushReady_o), .pushPc_i(pushPc),
    .pushPredTaken_i(pushPredTaken), .pushPredTarget_i(pushPredTarget),
    .resValid_i(resValid), .resPc_i(resPc), .resTaken_i(resTaken),
    .resTarget_i(resTarget), .resCompressed_i(resCompressed), .flush_i(flush),
    .redirectValid_o(redirectValid_o), .redirectPc_o(redirectPc_o),
    .updValid_o(updValid_o), .updTaken_o(updTaken_o), .updPc_o(updPc_o),
    .updTarget_o(updTarget_o), .err_o(err_o),
    .branchCnt_o(branchCnt_o), .mispredCnt_o(mispredCnt_o)
  );

  // Reference model: queue of outstanding predictions plus expected registered outputs.
  typedef struct {
    logic [31:0]   pc;
    logic          t;
    logic [TW-1:0] tgt;
  } ent_t;

  ent_t          mq[$];
  logic          e_upd_v, e_upd_t, e_rd_v, e_err, e_ready, o_ready;
  logic [31:0]   e_upd_pc, e_rd_pc;
  logic [TW-1:0] e_upd_tgt;
  int unsigned   e_bcnt, e_mcnt;
  int unsigned   n_cmp, n_fail;

  task automatic clear_inputs();
    pushValid = 0; pushPc = '0; pushPredTaken = 0; pushPredTarget = '0;
    resValid = 0; resPc = '0; resTaken = 0; resTarget = '0; resCompressed = 0; flush = 0;
  endtask

  task automatic push_in(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    pushValid = 1; pushPc = pc; pushPredTaken = t; pushPredTarget = tgt;
  endtask

  task automatic res_in(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic c);
    resValid = 1; resPc = pc; resTaken = t; resTarget = tgt; resCompressed = c;
  endtask

  // Advance one clock: predict from the current inputs, clock, then return inputs to idle.
  task automatic step();
    logic mis;
    e_ready = (mq.size() < DEPTH);
    o_ready = pushReady_o;
    if (!rstn) begin
      mq.delete();
      e_upd_v = 0; e_upd_t = 0; e_upd_pc = 0; e_upd_tgt = 0; e_rd_v = 0; e_rd_pc = 0;
      e_err = 0; e_bcnt = 0; e_mcnt = 0;
    end else begin
      mis = 0;
      if (resValid) begin
        if (mq.size() == 0 || mq[0].pc != resPc) begin
          mis = 1; e_err = 1;
        end else begin
          mis = (mq[0].t != resTaken) || (resTaken && mq[0].tgt != resTarget);
        end
        e_upd_v = 1; e_upd_t = resTaken; e_upd_pc = resPc; e_upd_tgt = resTarget;
        e_rd_v  = mis && !flush;
        e_rd_pc = !e_rd_v ? 32'd0 : (resTaken ? resTarget : resPc + (resCompressed ? 32'd2 : 32'd4));
        e_bcnt++;
        if (mis) e_mcnt++;
      end else begin
        e_upd_v = 0; e_upd_t = 0; e_upd_pc = 0; e_upd_tgt = 0; e_rd_v = 0; e_rd_pc = 0;
      end
      if (flush || mis) mq.delete();
      else begin
        if (resValid) void'(mq.pop_front());
        if (pushValid && e_ready) mq.push_back('{pc: pushPc, t: pushPredTaken, tgt: pushPredTarget});
      end
    end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    rstn = 0;
    push_in(32'h40, 1, 32'h80); res_in(32'h40, 0, 0, 0);
    step(); step();
    rstn = 1;
    n_cmp++; if (updValid_o !== 1'b0) begin n_fail++; $display("FAIL reset_updValid got=%b exp=0", updValid_o); end
    n_cmp++; if (redirectValid_o !== 1'b0) begin n_fail++; $display("FAIL reset_redirValid got=%b exp=0", redirectValid_o); end
    n_cmp++; if (redirectPc_o !== 32'h0) begin n_fail++; $display("FAIL reset_redirPc got=%h exp=0", redirectPc_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_o); end
    n_cmp++; if (pushReady_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", pushReady_o); end
    n_cmp++; if (branchCnt_o !== 32'h0 || mispredCnt_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt got=%h/%h exp=0/0", branchCnt_o, mispredCnt_o); end
  endtask

  task automatic test_correct_nt();
    push_in(32'h100, 0, 32'h0); step();
    res_in(32'h100, 0, 32'h0, 0); step();
    n_cmp++; if (updValid_o !== 1'b1 || updTaken_o !== 1'b0 || updPc_o !== 32'h100) begin
      n_fail++; $display("FAIL nt_update got=v%b t%b pc=%h exp=v1 t0 pc=100", updValid_o, updTaken_o, updPc_o); end
    n_cmp++; if (redirectValid_o !== 1'b0) begin n_fail++; $display("FAIL nt_noredir got=%b exp=0", redirectValid_o); end
    step();
    n_cmp++; if (updValid_o !== 1'b0 || updPc_o !== 32'h0 || redirectPc_o !== 32'h0) begin
      n_fail++; $display("FAIL idle_hold0 got=v%b pc=%h rpc=%h exp=0/0/0", updValid_o, updPc_o, redirectPc_o); end
  endtask

  task automatic test_target_mispredict();
    push_in(32'h200, 1, 32'h300); step();
    res_in(32'h200, 1, 32'h340, 0); step();
    n_cmp++; if (redirectValid_o !== 1'b1 || redirectPc_o !== 32'h340) begin
      n_fail++; $display("FAIL tgt_redir got=v%b pc=%h exp=v1 pc=340", redirectValid_o, redirectPc_o); end
    n_cmp++; if (updTarget_o !== 32'h340 || updTaken_o !== 1'b1) begin
      n_fail++; $display("FAIL tgt_update got=tgt%h t%b exp=340 t1", updTarget_o, updTaken_o); end
    n_cmp++; if (pushReady_o !== 1'b1) begin n_fail++; $display("FAIL tgt_ready got=%b exp=1", pushReady_o); end
  endtask

  task automatic test_dir_mispredict();
    push_in(32'h400, 1, 32'h500); step();
    res_in(32'h400, 0, 32'h0, 1); step();
    n_cmp++; if (redirectValid_o !== 1'b1 || redirectPc_o !== 32'h402) begin
      n_fail++; $display("FAIL dir_c16 got=v%b pc=%h exp=v1 pc=402", redirectValid_o, redirectPc_o); end
    push_in(32'h400, 1, 32'h500); step();
    res_in(32'h400, 0, 32'h0, 0); step();
    n_cmp++; if (redirectValid_o !== 1'b1 || redirectPc_o !== 32'h404) begin
      n_fail++; $display("FAIL dir_c32 got=v%b pc=%h exp=v1 pc=404", redirectValid_o, redirectPc_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      push_in(32'h1000 + 32'(16 * i), 0, 32'h0); step();
    end
    n_cmp++; if (pushReady_o !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", pushReady_o); end
    push_in(32'h2000, 0, 32'h0); step();
    n_cmp++; if (pushReady_o !== 1'b0) begin n_fail++; $display("FAIL full_drop_ready got=%b exp=0", pushReady_o); end
    push_in(32'h3000, 0, 32'h0); res_in(32'h1000, 0, 32'h0, 0); step();
    n_cmp++; if (o_ready !== 1'b0 || pushReady_o !== 1'b1) begin
      n_fail++; $display("FAIL full_pushpop got=pre%b post%b exp=pre0 post1", o_ready, pushReady_o); end
    for (int i = 1; i < DEPTH; i++) begin
      res_in(32'h1000 + 32'(16 * i), 0, 32'h0, 0); step();
      n_cmp++; if (redirectValid_o !== 1'b0 || err_o !== 1'b0) begin
        n_fail++; $display("FAIL full_order[%0d] got=redir%b err%b exp=0/0", i, redirectValid_o, err_o); end
    end
    // 0x3000 must have been dropped: resolving it now is an ordering error seen by the model.
  endtask

  task automatic test_flush();
    int unsigned eb, em;
    push_in(32'hA0, 0, 0); step();
    push_in(32'hB0, 0, 0); step();
    push_in(32'hC0, 0, 0); step();
    flush = 1; push_in(32'hD0, 0, 0); res_in(32'hA0, 1, 32'h50, 0); step();
    n_cmp++; if (updValid_o !== 1'b1 || updTaken_o !== 1'b1 || redirectValid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_resolve got=upd%b t%b redir%b exp=1/1/0", updValid_o, updTaken_o, redirectValid_o); end
    push_in(32'hE0, 0, 0); step();
    res_in(32'hE0, 0, 0, 0); step();
    n_cmp++; if (redirectValid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty got=redir%b err%b exp=0/0", redirectValid_o, err_o); end
`ifdef BRU_PERF_CNT_EN
    eb = e_bcnt; em = e_mcnt;
`else
    eb = 0; em = 0;
`endif
    n_cmp++; if (branchCnt_o !== eb || mispredCnt_o !== em) begin
      n_fail++; $display("FAIL flush_cnt got=%0d/%0d exp=%0d/%0d", branchCnt_o, mispredCnt_o, eb, em); end
  endtask

  task automatic test_err();
    res_in(32'h800, 0, 32'h0, 0); step();
    n_cmp++; if (err_o !== 1'b1 || redirectValid_o !== 1'b1 || redirectPc_o !== 32'h804) begin
      n_fail++; $display("FAIL err_empty got=err%b redir%b pc=%h exp=1/1/804", err_o, redirectValid_o, redirectPc_o); end
    n_cmp++; if (updValid_o !== 1'b1 || updPc_o !== 32'h800) begin
      n_fail++; $display("FAIL err_update got=v%b pc=%h exp=1/800", updValid_o, updPc_o); end
    push_in(32'h900, 1, 32'h990); step();
    res_in(32'h904, 1, 32'hA00, 0); step();
    n_cmp++; if (redirectValid_o !== 1'b1 || redirectPc_o !== 32'hA00) begin
      n_fail++; $display("FAIL err_pcmis got=redir%b pc=%h exp=1/a00", redirectValid_o, redirectPc_o); end
    step();
    n_cmp++; if (err_o !== 1'b1 || redirectValid_o !== 1'b0) begin
      n_fail++; $display("FAIL err_sticky got=err%b redir%b exp=1/0", err_o, redirectValid_o); end
  endtask

  task automatic test_reset_mid();
    push_in(32'h10, 0, 0); step();
    push_in(32'h20, 0, 0); step();
    rstn = 0; res_in(32'h20, 1, 32'h77, 0); step();
    rstn = 1;
    n_cmp++; if (redirectValid_o !== 1'b0 || updValid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_out got=redir%b upd%b err%b exp=0/0/0", redirectValid_o, updValid_o, err_o); end
    push_in(32'h30, 0, 0); step();
    res_in(32'h30, 0, 0, 0); step();
    n_cmp++; if (redirectValid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_empty got=redir%b err%b exp=0/0", redirectValid_o, err_o); end
  endtask

  task automatic test_random();
    int unsigned eb, em;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) != 0) push_in(32'($urandom_range(0, 1023)) << 1, 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        if (mq.size() > 0 && $urandom_range(0, 15) != 0)
          res_in(mq[0].pc,
                 ($urandom_range(0, 7) == 0) ? ~mq[0].t : mq[0].t,
                 ($urandom_range(0, 7) == 0) ? $urandom : mq[0].tgt,
                 1'($urandom_range(0, 1)));
        else
          res_in(32'($urandom_range(0, 1023)) << 1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
      flush = ($urandom_range(0, 31) == 0);
      step();
`ifdef BRU_PERF_CNT_EN
      eb = e_bcnt; em = e_mcnt;
`else
      eb = 0; em = 0;
`endif
      n_cmp++; if (o_ready !== e_ready) begin
        n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, o_ready, e_ready); end
      n_cmp++; if (updValid_o !== e_upd_v || updTaken_o !== e_upd_t || updPc_o !== e_upd_pc || updTarget_o !== e_upd_tgt) begin
        n_fail++; $display("FAIL rnd_upd cyc=%0d got=%b/%b/%h/%h exp=%b/%b/%h/%h", cyc, updValid_o, updTaken_o,
                           updPc_o, updTarget_o, e_upd_v, e_upd_t, e_upd_pc, e_upd_tgt); end
      n_cmp++; if (redirectValid_o !== e_rd_v || redirectPc_o !== e_rd_pc) begin
        n_fail++; $display("FAIL rnd_redir cyc=%0d got=%b/%h exp=%b/%h", cyc, redirectValid_o, redirectPc_o, e_rd_v, e_rd_pc); end
      n_cmp++; if (err_o !== e_err) begin
        n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_o, e_err); end
      n_cmp++; if (branchCnt_o !== eb || mispredCnt_o !== em) begin
        n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, branchCnt_o, mispredCnt_o, eb, em); end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    e_bcnt = 0; e_mcnt = 0; e_err = 0;
    rstn = 0;
    clear_inputs();
    test_reset();
    test_correct_nt();
    test_target_mispredict();
    test_dir_mispredict();
    test_full();
    test_flush();
    test_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
